// File: rtl/multi_channel_up_down_counter_pkg.sv
// Shared types and default sizing for the multi-channel up/down counter.
// Build option: MULTI_CNT_WRAP_EN selects wrap-around instead of saturation.
package multi_channel_up_down_counter_pkg;

    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } counter_mode_e;

    localparam int NUM_CH_DEF     = 4;
    localparam int MAX_COUNT_DEF  = 8;
    localparam int STEP_WIDTH_DEF = 2;

    function automatic int count_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/multi_channel_up_down_counter_if.sv
// Multi-channel counter bundle with DUT and testbench views.
// Build option: MULTI_CNT_WRAP_EN (affects Sat meaning only).
interface multi_channel_up_down_counter_if
    import multi_channel_up_down_counter_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int MAX_COUNT   = MAX_COUNT_DEF,
    parameter int COUNT_WIDTH = $clog2(MAX_COUNT + 1),
    parameter int STEP_WIDTH  = STEP_WIDTH_DEF
) (
    input logic ACLK
);

    logic                          ARESET;
    logic [NUM_CH-1:0]             En;
    logic [NUM_CH-1:0]             Mode;
    logic [NUM_CH*STEP_WIDTH-1:0]  Step;
    logic [NUM_CH-1:0]             Load;
    logic [NUM_CH*COUNT_WIDTH-1:0] Load_Count;
    logic [NUM_CH*COUNT_WIDTH-1:0] Count;
    logic [NUM_CH-1:0]             Done;
    logic [NUM_CH-1:0]             Hit;
    logic [NUM_CH-1:0]             Sat;

    modport dut (
        input  ACLK, ARESET, En, Mode, Step, Load, Load_Count,
        output Count, Done, Hit, Sat
    );

    modport tb (
        input  ACLK, Count, Done, Hit, Sat,
        output ARESET, En, Mode, Step, Load, Load_Count
    );

endinterface

// File: rtl/multi_channel_up_down_counter_channel.sv
// One counter slice: load clamp, stepped up/down count, Hit and Sat pulses.
// Build option: MULTI_CNT_WRAP_EN wraps modulo MAX_COUNT+1 instead of clipping.
module up_down_counter_channel
    import multi_channel_up_down_counter_pkg::*;
#(
    parameter int MAX_COUNT   = MAX_COUNT_DEF,
    parameter int COUNT_WIDTH = $clog2(MAX_COUNT + 1),
    parameter int STEP_WIDTH  = STEP_WIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   mode_i,
    input  logic [STEP_WIDTH-1:0]  step_i,
    input  logic                   load_i,
    input  logic [COUNT_WIDTH-1:0] load_val_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   done_o,
    output logic                   hit_o,
    output logic                   sat_o
);

    localparam int CW = COUNT_WIDTH;
    localparam int WW = COUNT_WIDTH + STEP_WIDTH + 1;

    localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);
    localparam logic [WW-1:0] MAX_W = WW'(MAX_COUNT);
`ifdef MULTI_CNT_WRAP_EN
    localparam logic [WW-1:0] MOD_W = WW'(MAX_COUNT + 1);
`endif

    counter_mode_e   mode_e;
    logic [CW-1:0]   count_q, count_d;
    logic            hit_q, hit_d;
    logic            sat_q, sat_d;
    logic [CW-1:0]   term;
    logic [WW-1:0]   cnt_w, step_w, sum_w;

    assign mode_e = counter_mode_e'(mode_i);
    assign term   = (mode_e == CNT_DOWN) ? '0 : MAX_C;
    assign cnt_w  = WW'(count_q);
    assign step_w = WW'(step_i);
    assign sum_w  = cnt_w + step_w;

    always_comb begin
        count_d = count_q;
        sat_d   = 1'b0;
        if (load_i) begin
            if (load_val_i > MAX_C) begin
                count_d = MAX_C;
                sat_d   = 1'b1;
            end else begin
                count_d = load_val_i;
            end
        end else if (en_i && (step_i != '0)) begin
            if (mode_e == CNT_UP) begin
                if (sum_w > MAX_W) begin
`ifdef MULTI_CNT_WRAP_EN
                    count_d = CW'(sum_w % MOD_W);
`else
                    count_d = MAX_C;
`endif
                    sat_d = 1'b1;
                end else begin
                    count_d = CW'(sum_w);
                end
            end else begin
                if (step_w > cnt_w) begin
`ifdef MULTI_CNT_WRAP_EN
                    // Borrow one full modulus so the subtraction stays positive.
                    count_d = CW'((cnt_w + MOD_W - (step_w % MOD_W)) % MOD_W);
`else
                    count_d = '0;
`endif
                    sat_d = 1'b1;
                end else begin
                    count_d = CW'(cnt_w - step_w);
                end
            end
        end
        hit_d = (count_d == term) && (count_d != count_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            hit_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            hit_q   <= hit_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == term);
    assign hit_o   = hit_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/multi_channel_up_down_counter.sv
// NUM_CH independent saturating up/down counters with packed channel buses.
// Build option: MULTI_CNT_WRAP_EN turns saturation into modulo wrap.
module multi_channel_up_down_counter
    import multi_channel_up_down_counter_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int MAX_COUNT   = MAX_COUNT_DEF,
    parameter int COUNT_WIDTH = $clog2(MAX_COUNT + 1),
    parameter int STEP_WIDTH  = STEP_WIDTH_DEF
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_CH-1:0]             En,
    input  logic [NUM_CH-1:0]             Mode,
    input  logic [NUM_CH*STEP_WIDTH-1:0]  Step,
    input  logic [NUM_CH-1:0]             Load,
    input  logic [NUM_CH*COUNT_WIDTH-1:0] Load_Count,
    output logic [NUM_CH*COUNT_WIDTH-1:0] Count,
    output logic [NUM_CH-1:0]             Done,
    output logic [NUM_CH-1:0]             Hit,
    output logic [NUM_CH-1:0]             Sat
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        up_down_counter_channel #(
            .MAX_COUNT   (MAX_COUNT),
            .COUNT_WIDTH (COUNT_WIDTH),
            .STEP_WIDTH  (STEP_WIDTH)
        ) u_ch (
            .clk_i      (ACLK),
            .rst_i      (ARESET),
            .en_i       (En[i]),
            .mode_i     (Mode[i]),
            .step_i     (Step[i*STEP_WIDTH +: STEP_WIDTH]),
            .load_i     (Load[i]),
            .load_val_i (Load_Count[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .count_o    (Count[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .done_o     (Done[i]),
            .hit_o      (Hit[i]),
            .sat_o      (Sat[i])
        );
    end

endmodule
